dsd_dop_packer: RTL and testbench

- Downstream neighbour of the delta-sigma modulator. Consumes its 1-bit DSD stream (dsd_bit qualified by the dsd_ce strobe).
- Packs 16 consecutive DSD bits into 24-bit DSD-over-PCM (DoP) words: 8-bit alternating marker plus 16 DSD bits.
- Buffers the words in a small FIFO and presents them on a valid/ready interface to the PCM/I2S transmit path.

---
 rtl/dsd_dop_packer.sv | 135 +++++++++++++
 tb/tb_dsd_dop_packer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dsd_dop_packer.sv
// Packs the 1-bit DSD stream into 24-bit DoP words {marker, 16 DSD bits} and
// queues them in a first-word-fall-through FIFO for the PCM/I2S transmit path.
module dsd_dop_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  MARKER_A   = 8'h05,
  parameter logic [7:0]  MARKER_B   = 8'hFA
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                dsd_bit,
  input  logic                                dsd_ce,
  output logic [23:0]                         out_word,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                overflow,
  input  logic                                overflow_clr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    PH_A,
    PH_B
  } phase_e;

  phase_e          phase_q, phase_d;
  logic [15:0]     sreg_q, sreg_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [23:0]     mem_q [FIFO_DEPTH];

  logic            shift;
  logic            word_done;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic            drop;
  logic [7:0]      marker;
  logic [23:0]     push_word;

  always_comb begin
    shift     = en && dsd_ce;
    word_done = shift && (bit_cnt_q == 4'd15);
    full      = (level_q == LW'(FIFO_DEPTH));
    pop       = (level_q != '0) && out_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    push_ok   = word_done && (!full || pop);
    drop      = word_done && full && !pop;
    marker    = (phase_q == PH_A) ? MARKER_A : MARKER_B;
    push_word = {marker, sreg_q[14:0], dsd_bit};
  end

  always_comb begin
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    if (!en) begin
      sreg_d    = '0;
      bit_cnt_d = '0;
      phase_d   = PH_A;
    end else begin
      if (shift) begin
        sreg_d    = {sreg_q[14:0], dsd_bit};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      // Only delivered words flip the marker, so the output stream alternates.
      if (push_ok) begin
        phase_d = (phase_q == PH_A) ? PH_B : PH_A;
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH_A;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  always_comb begin
    out_word  = mem_q[rd_ptr_q];
    out_valid = (level_q != '0);
    level     = level_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_dsd_dop_packer.sv
// Directed bench for dsd_dop_packer: a table of single-word vectors followed by
// hand-written overflow, full-with-pop and enable-drop sequences.
module tb_dsd_dop_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        dsd_bit;
  logic        dsd_ce;
  logic [23:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        overflow_clr;
  logic [2:0]  level;

  int n_vec = 0;
  int n_err = 0;

  dsd_dop_packer #(
    .FIFO_DEPTH (4),
    .MARKER_A   (8'h05),
    .MARKER_B   (8'hFA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .dsd_bit      (dsd_bit),
    .dsd_ce       (dsd_ce),
    .out_word     (out_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .level        (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    logic [23:0] exp_word;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Sends 16 bits MSB first, gap idle cycles between strobes. Returns level as
  // seen just before the last strobe; optionally raises out_ready for exactly
  // the edge that completes the word. Ends on the negedge after that edge.
  task automatic send_word(input logic [15:0] w, input int gap, input bit rdy_last,
                           output logic [2:0] pre_lvl);
    pre_lvl = '0;
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      dsd_ce  = 1'b1;
      dsd_bit = w[i];
      if (i == 0) begin
        pre_lvl = level;
        if (rdy_last) out_ready = 1'b1;
      end
      @(negedge clk);
      dsd_ce = 1'b0;
      if (i == 0 && rdy_last) out_ready = 1'b0;
      if (i != 0) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic drain_chk(input string name, input logic [23:0] exp);
    chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, ".word"}, {8'd0, out_word}, {8'd0, exp});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] pl;

    vecs[0] = '{16'hAAAA, 24'h05AAAA};
    vecs[1] = '{16'hFFFF, 24'hFAFFFF};
    vecs[2] = '{16'h0000, 24'h050000};
    vecs[3] = '{16'h1234, 24'hFA1234};
    vecs[4] = '{16'h8001, 24'h058001};

    rst = 1'b1; en = 1'b1; dsd_bit = 1'b1; dsd_ce = 1'b0;
    out_ready = 1'b1; overflow_clr = 1'b0;

    // Reset held while the strobe toggles.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst.valid", {31'd0, out_valid}, 32'd0);
      chk("rst.level", {29'd0, level}, 32'd0);
      chk("rst.ovf", {31'd0, overflow}, 32'd0);
      dsd_ce = ~dsd_ce;
    end
    @(negedge clk);
    dsd_ce = 1'b0;
    rst = 1'b0;

    // Table: each word appears one cycle after its 16th strobe, for one cycle.
    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].bits, 30, 1'b0, pl);
      chk("tbl.pre_level", {29'd0, pl}, 32'd0);
      chk("tbl.valid", {31'd0, out_valid}, 32'd1);
      chk("tbl.word", {8'd0, out_word}, {8'd0, vecs[v].exp_word});
      @(negedge clk);
      chk("tbl.valid_gone", {31'd0, out_valid}, 32'd0);
    end

    // Re-arm marker A, then overflow with the consumer stalled.
    @(negedge clk);
    en = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_word(16'hFFFF, 1, 1'b0, pl);
      chk("ovf.level", {29'd0, level}, (k < 4) ? k + 1 : 4);
      chk("ovf.flag", {31'd0, overflow}, (k < 4) ? 32'd0 : 32'd1);
    end
    drain_chk("ovf.d0", 24'h05FFFF);
    drain_chk("ovf.d1", 24'hFAFFFF);
    drain_chk("ovf.d2", 24'h05FFFF);
    drain_chk("ovf.d3", 24'hFAFFFF);
    chk("ovf.empty", {29'd0, level}, 32'd0);
    send_word(16'h0F0F, 1, 1'b0, pl);
    drain_chk("ovf.next", 24'h050F0F);
    chk("ovf.sticky", {31'd0, overflow}, 32'd1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    chk("ovf.clr", {31'd0, overflow}, 32'd0);

    // Full FIFO with a pop on the completing edge.
    send_word(16'h1111, 1, 1'b0, pl);
    send_word(16'h2222, 1, 1'b0, pl);
    send_word(16'h3333, 1, 1'b0, pl);
    send_word(16'h4444, 1, 1'b0, pl);
    chk("full.level", {29'd0, level}, 32'd4);
    send_word(16'h5555, 1, 1'b1, pl);
    chk("full.pre", {29'd0, pl}, 32'd4);
    chk("full.level_kept", {29'd0, level}, 32'd4);
    chk("full.no_ovf", {31'd0, overflow}, 32'd0);
    drain_chk("full.d0", 24'h052222);
    drain_chk("full.d1", 24'hFA3333);
    drain_chk("full.d2", 24'h054444);
    drain_chk("full.d3", 24'hFA5555);
    chk("full.empty", {31'd0, out_valid}, 32'd0);

    // Enable drop mid-word with one word already queued.
    send_word(16'hBEEF, 1, 1'b0, pl);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); dsd_ce = 1'b1; dsd_bit = 1'b1;
      @(negedge clk); dsd_ce = 1'b0;
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dsd_ce = (i % 2 == 0);
    end
    dsd_ce = 1'b0;
    en = 1'b1;
    chk("en.level_kept", {29'd0, level}, 32'd1);
    send_word(16'h0000, 1, 1'b0, pl);
    chk("en.pre_level", {29'd0, pl}, 32'd1);
    chk("en.level", {29'd0, level}, 32'd2);
    drain_chk("en.d0", 24'h05BEEF);
    drain_chk("en.d1", 24'h050000);
    chk("en.empty", {29'd0, level}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
